// File: rtl/dbi_tx_seq.sv
// DBI Type-B transmit sequencer: hardware reset, sleep-out, window and display-on
// commands, then memory-write frames sized from the latched window.
module dbi_tx_seq #(
  parameter int unsigned CLK_FREQ     = 125000000,
  parameter int unsigned DBI_IF_D_W   = 8,
  parameter int unsigned COORD_W      = 16,
  parameter int unsigned PXL_BYTES    = 2,
  parameter int unsigned RST_STALL_US = 5000,
  parameter int unsigned SLP_STALL_US = 120000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  cont_mode_i,
  input  logic [DBI_IF_D_W-1:0] addr_slp_out_i,
  input  logic [DBI_IF_D_W-1:0] addr_col_i,
  input  logic [DBI_IF_D_W-1:0] addr_row_i,
  input  logic [DBI_IF_D_W-1:0] addr_disp_on_i,
  input  logic [DBI_IF_D_W-1:0] addr_mem_wr_i,
  input  logic [COORD_W-1:0]    s_col_i,
  input  logic [COORD_W-1:0]    e_col_i,
  input  logic [COORD_W-1:0]    s_row_i,
  input  logic [COORD_W-1:0]    e_row_i,
  input  logic [DBI_IF_D_W-1:0] pxl_d_i,
  input  logic                  pxl_vld_i,
  output logic                  pxl_rdy_o,
  input  logic                  dtp_tx_rdy_i,
  output logic                  dtp_dbi_hrst_o,
  output logic                  dtp_tx_last_o,
  output logic                  dtp_tx_no_dat_o,
  output logic                  dtp_tx_vld_o,
  output logic [DBI_IF_D_W-1:0] dtp_tx_cmd_typ_o,
  output logic [DBI_IF_D_W-1:0] dtp_tx_cmd_dat_o,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic                  win_err_o,
  output logic [3:0]            dbg_state_o
);

  // Handshake: a byte moves to the PHY only in a cycle where dtp_tx_vld_o and
  // dtp_tx_rdy_i are both high; vld never depends on rdy, and in MEM the pixel
  // FIFO sees rdy straight through so FIFO pop and PHY transfer coincide.

  localparam int unsigned RST_CYC = CLK_FREQ / 1000000 * RST_STALL_US;
  localparam int unsigned SLP_CYC = CLK_FREQ / 1000000 * SLP_STALL_US;
  localparam int unsigned MAX_CYC = (RST_CYC > SLP_CYC) ? RST_CYC : SLP_CYC;
  localparam int unsigned STALL_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int unsigned CNT_W   = 2 * COORD_W + 2;
  // The wait state itself counts down to zero, so load one less than the stall.
  localparam logic [STALL_W-1:0] RST_LOAD = (RST_CYC > 0) ? STALL_W'(RST_CYC - 1) : '0;
  localparam logic [STALL_W-1:0] SLP_LOAD = (SLP_CYC > 0) ? STALL_W'(SLP_CYC - 1) : '0;

  typedef enum logic [3:0] {
    S_IDLE, S_HRST, S_RST_WAIT, S_SLPOUT, S_SLP_WAIT, S_COL, S_ROW, S_DISP, S_MEM
  } state_e;

  state_e               state_q, state_d;
  logic [STALL_W-1:0]   stall_q, stall_d;
  logic [1:0]           byte_q, byte_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [COORD_W-1:0]   sc_q, ec_q, sr_q, er_q;
  logic                 lat_en;

  logic                 xfer, in_bad, win_same, mem_last;
  logic [COORD_W:0]     win_w, win_h;
  logic [CNT_W-1:0]     frame_len;
  logic [COORD_W-1:0]   coord_sel;
  logic [DBI_IF_D_W-1:0] coord_byte;

  assign win_w     = {1'b0, ec_q} - {1'b0, sc_q} + (COORD_W+1)'(1);
  assign win_h     = {1'b0, er_q} - {1'b0, sr_q} + (COORD_W+1)'(1);
  assign frame_len = CNT_W'(win_w) * CNT_W'(win_h) * CNT_W'(PXL_BYTES);
  assign mem_last  = (cnt_q == frame_len - CNT_W'(1));

  assign in_bad   = (e_col_i < s_col_i) || (e_row_i < s_row_i);
  assign win_same = ({s_col_i, e_col_i, s_row_i, e_row_i} == {sc_q, ec_q, sr_q, er_q});

  // Window bytes go out as start hi/lo then end hi/lo.
  always_comb begin
    if (state_q == S_COL) coord_sel = byte_q[1] ? ec_q : sc_q;
    else                  coord_sel = byte_q[1] ? er_q : sr_q;
    coord_byte = byte_q[0] ? DBI_IF_D_W'(coord_sel) : DBI_IF_D_W'(coord_sel >> DBI_IF_D_W);
  end

  always_comb begin
    dtp_dbi_hrst_o   = 1'b0;
    dtp_tx_last_o    = 1'b0;
    dtp_tx_no_dat_o  = 1'b0;
    dtp_tx_vld_o     = 1'b0;
    dtp_tx_cmd_typ_o = '0;
    dtp_tx_cmd_dat_o = '0;
    pxl_rdy_o        = 1'b0;
    case (state_q)
      S_HRST: begin
        dtp_tx_vld_o   = 1'b1;
        dtp_dbi_hrst_o = 1'b1;
      end
      S_SLPOUT: begin
        dtp_tx_vld_o     = 1'b1;
        dtp_tx_no_dat_o  = 1'b1;
        dtp_tx_last_o    = 1'b1;
        dtp_tx_cmd_typ_o = addr_slp_out_i;
      end
      S_COL, S_ROW: begin
        dtp_tx_vld_o     = 1'b1;
        dtp_tx_last_o    = (byte_q == 2'd3);
        dtp_tx_cmd_typ_o = (state_q == S_COL) ? addr_col_i : addr_row_i;
        dtp_tx_cmd_dat_o = coord_byte;
      end
      S_DISP: begin
        dtp_tx_vld_o     = 1'b1;
        dtp_tx_no_dat_o  = 1'b1;
        dtp_tx_last_o    = 1'b1;
        dtp_tx_cmd_typ_o = addr_disp_on_i;
      end
      S_MEM: begin
        dtp_tx_vld_o     = pxl_vld_i;
        dtp_tx_last_o    = mem_last;
        dtp_tx_cmd_typ_o = addr_mem_wr_i;
        dtp_tx_cmd_dat_o = pxl_d_i;
        pxl_rdy_o        = dtp_tx_rdy_i;
      end
      default: ;
    endcase
  end

  assign xfer        = dtp_tx_vld_o & dtp_tx_rdy_i;
  assign busy_o      = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

  always_comb begin
    state_d      = state_q;
    stall_d      = stall_q;
    byte_d       = byte_q;
    cnt_d        = cnt_q;
    lat_en       = 1'b0;
    frame_done_o = 1'b0;
    win_err_o    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          lat_en = 1'b1;
          if (in_bad) win_err_o = 1'b1;
          else        state_d   = S_HRST;
        end
      end
      S_HRST: begin
        if (xfer) begin
          state_d = S_RST_WAIT;
          stall_d = RST_LOAD;
        end
      end
      S_RST_WAIT: begin
        if (stall_q == '0) state_d = S_SLPOUT;
        else               stall_d = stall_q - STALL_W'(1);
      end
      S_SLPOUT: begin
        if (xfer) begin
          state_d = S_SLP_WAIT;
          stall_d = SLP_LOAD;
        end
      end
      S_SLP_WAIT: begin
        if (stall_q == '0) state_d = S_COL;
        else               stall_d = stall_q - STALL_W'(1);
      end
      S_COL, S_ROW: begin
        if (xfer) begin
          byte_d = byte_q + 2'd1;
          if (byte_q == 2'd3) state_d = (state_q == S_COL) ? S_ROW : S_DISP;
        end
      end
      S_DISP: begin
        if (xfer) state_d = S_MEM;
      end
      S_MEM: begin
        if (xfer) begin
          if (mem_last) begin
            frame_done_o = 1'b1;
            cnt_d        = '0;
            if (!start_i || !cont_mode_i) begin
              state_d = S_IDLE;
            end else begin
              // Next frame: reuse the open window unless the registers moved.
              lat_en = 1'b1;
              if (in_bad) begin
                win_err_o = 1'b1;
                state_d   = S_IDLE;
              end else if (!win_same) begin
                state_d = S_COL;
              end
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      stall_q <= '0;
      byte_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      byte_q  <= byte_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (lat_en) begin
      sc_q <= s_col_i;
      ec_q <= e_col_i;
      sr_q <= s_row_i;
      er_q <= e_row_i;
    end
  end

endmodule
